// File: rtl/dual_path_fetch_pc_if.sv
// ---------------------------------------------------------------------------
// dual_path_fetch_pc_if
//   Bundles the control inputs and fetch outputs of dual_path_fetch_pc.
//
//   Inputs to the PC stage (driven by master):
//     stall         hazard stall, holds both PCs
//     branch_ID     branch decoded in ID of the primary pipe
//     BTA_ID        target of that branch
//     correct_en_t  t pipe is wrong, redirect to correction_t
//     correction_t  redirect PC for t
//     correct_en_n  n pipe is wrong, redirect to correction_n
//     correction_n  redirect PC for n
//   Outputs of the PC stage (driven by slave):
//     pc_n, pc_t            per-pipe fetch PCs
//     nextPC_n, nextPC_t    PC+1, wrapping modulo 2^PC_W
//     fetch_en_n, fetch_en_t per-pipe fetch valid
//     forked                block is in the FORKED state
//     primary               surviving pipe after a merge (0 = n, 1 = t)
//
//   There is no valid/ready handshake on this bus: every input is sampled
//   on each rising clk edge, and every output is valid on every cycle.
// ---------------------------------------------------------------------------
interface dual_path_fetch_pc_if #(
   parameter int PC_W = 10
);
   logic            stall;
   logic            branch_ID;
   logic [PC_W-1:0] BTA_ID;
   logic            correct_en_t;
   logic [PC_W-1:0] correction_t;
   logic            correct_en_n;
   logic [PC_W-1:0] correction_n;

   logic [PC_W-1:0] pc_n;
   logic [PC_W-1:0] pc_t;
   logic [PC_W-1:0] nextPC_n;
   logic [PC_W-1:0] nextPC_t;
   logic            fetch_en_n;
   logic            fetch_en_t;
   logic            forked;
   logic            primary;

   modport master (
      output stall, branch_ID, BTA_ID,
             correct_en_t, correction_t, correct_en_n, correction_n,
      input  pc_n, pc_t, nextPC_n, nextPC_t,
             fetch_en_n, fetch_en_t, forked, primary
   );

   modport slave (
      input  stall, branch_ID, BTA_ID,
             correct_en_t, correction_t, correct_en_n, correction_n,
      output pc_n, pc_t, nextPC_n, nextPC_t,
             fetch_en_n, fetch_en_t, forked, primary
   );
endinterface

// File: rtl/dual_path_fetch_pc.sv
// ---------------------------------------------------------------------------
// dual_path_fetch_pc
//   PC generation stage for dual-path fetch.  In SINGLE only the primary pipe
//   fetches and the other PC mirrors it.  A branch in ID forks the block into
//   FORKED, where pipe n follows the fall-through path and pipe t the branch
//   target.  A correction for either pipe merges both PCs onto the corrected
//   address and returns to SINGLE with the other pipe as primary.
//
//   Ports:
//     clk   clock
//     rst   asynchronous active-low reset
//     bus   dual_path_fetch_pc_if.slave (controls in, PCs/enables out)
//
//   Parameters:
//     PC_W        width of all PCs and correction buses
//     FORK_LIMIT  FORKED cycles after which the t pipe is throttled
//
//   Optional feature, macro FORK_LIMIT_EN:
//     defined   - a fork counter saturating at FORK_LIMIT stops the t pipe
//                 (fetch_en_t = 0, pc_t holds) once the limit is reached
//     undefined - no counter; the t pipe fetches for the whole fork
//
//   pc_n, pc_t and primary come straight from registers; nextPC_*,
//   fetch_en_* and forked are decoded from registers only.
// ---------------------------------------------------------------------------
module dual_path_fetch_pc #(
   parameter int PC_W       = 10,
   parameter int FORK_LIMIT = 4
) (
   input logic                 clk,
   input logic                 rst,
   dual_path_fetch_pc_if.slave bus
);

   typedef enum logic {
      SINGLE = 1'b0,
      FORKED = 1'b1
   } state_t;

   if (FORK_LIMIT < 1) begin : g_bad_limit
      $error("FORK_LIMIT must be at least 1");
   end

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_n_q, pc_n_d;
   logic [PC_W-1:0] pc_t_q, pc_t_d;
   logic            primary_q, primary_d;
   logic [PC_W-1:0] prim_pc;
   logic            throttled;

   assign prim_pc = primary_q ? pc_t_q : pc_n_q;

`ifdef FORK_LIMIT_EN
   localparam int CNT_W = $clog2(FORK_LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             fork_start;
   logic             fork_adv;

   // Counter only moves on cycles where the fork actually advances; a
   // correction or stall leaves it alone (a correction ends the fork anyway).
   assign fork_start = (state_q == SINGLE) && !bus.correct_en_n &&
                       !bus.correct_en_t && !bus.stall && bus.branch_ID;
   assign fork_adv   = (state_q == FORKED) && !bus.correct_en_n &&
                       !bus.correct_en_t && !bus.stall;
   assign throttled  = (state_q == FORKED) && (cnt_q == CNT_W'(FORK_LIMIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else if (fork_start)
         cnt_q <= '0;
      else if (fork_adv && !throttled)
         cnt_q <= cnt_q + CNT_W'(1);
   end
`else
   assign throttled = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= SINGLE;
         pc_n_q    <= '0;
         pc_t_q    <= '0;
         primary_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_n_q    <= pc_n_d;
         pc_t_q    <= pc_t_d;
         primary_q <= primary_d;
      end
   end

   // Next-state and next-PC logic.
   // Priority: correct_en_n > correct_en_t > stall > branch_ID > increment.
   always_comb begin
      state_d   = state_q;
      pc_n_d    = pc_n_q;
      pc_t_d    = pc_t_q;
      primary_d = primary_q;
      if (bus.correct_en_n) begin
         // n was wrong: t survives.
         pc_n_d    = bus.correction_n;
         pc_t_d    = bus.correction_n;
         primary_d = 1'b1;
         state_d   = SINGLE;
      end else if (bus.correct_en_t) begin
         // t was wrong: n survives.
         pc_n_d    = bus.correction_t;
         pc_t_d    = bus.correction_t;
         primary_d = 1'b0;
         state_d   = SINGLE;
      end else if (bus.stall) begin
         state_d = state_q;
      end else if (state_q == SINGLE) begin
         if (bus.branch_ID) begin
            pc_n_d    = prim_pc + PC_W'(1);
            pc_t_d    = bus.BTA_ID;
            primary_d = 1'b0;
            state_d   = FORKED;
         end else begin
            // Non-primary PC keeps mirroring the primary one.
            pc_n_d = prim_pc + PC_W'(1);
            pc_t_d = prim_pc + PC_W'(1);
         end
      end else begin
         pc_n_d = pc_n_q + PC_W'(1);
         if (!throttled)
            pc_t_d = pc_t_q + PC_W'(1);
      end
   end

   // Output decode.
   always_comb begin
      bus.pc_n     = pc_n_q;
      bus.pc_t     = pc_t_q;
      bus.nextPC_n = pc_n_q + PC_W'(1);
      bus.nextPC_t = pc_t_q + PC_W'(1);
      bus.primary  = primary_q;
      bus.forked   = (state_q == FORKED);
      if (state_q == FORKED) begin
         bus.fetch_en_n = 1'b1;
         bus.fetch_en_t = !throttled;
      end else begin
         bus.fetch_en_n = !primary_q;
         bus.fetch_en_t = primary_q;
      end
   end

endmodule
